pcs_reset_seq: RTL and testbench
================================

// Module: pcs_reset_seq
// PURPOSE
//  Downstream consumer of the FPGA fake-reset generator in board testbenches.
//  Turns the raw reset trigger into a staged PCS reset sequence:
//   - hold TX and RX in reset;
//   - release TX, let it settle;
//   - release RX and wait for block lock, with timeout and retry;
//   - report link ready.
//  Sits between fake reset / board reset and the PCS TX/RX datapaths.
// PARAMETERS
//  HOLD_CYC      16    cycles both resets held after reset/trigger; also RX re-reset length on retry
//  TX_SETTLE_CYC 8     cycles between TX reset release and RX reset release
//  LOCK_TIMEOUT  1024  cycles allowed in WAIT_LOCK before a retry
//  RETRY_W       8     width of saturating retry counter
//  CNT_W         derived: $clog2(max(HOLD_CYC,TX_SETTLE_CYC,LOCK_TIMEOUT)+1); not user-set
//  Constraint: all cycle parameters >= 1 (elaboration-time check).
// PORTS
//  clk           in   1        single clock domain
//  fpga_reset_i  in   1        synchronous, active-high reset
//  trig_i        in   1        restart request, driven by fake_reset_o; single-cycle pulse or level
//  block_lock_i  in   1        RX block-sync lock status, synchronous to clk
//  tx_reset_o    out  1        PCS TX reset, active-high
//  rx_reset_o    out  1        PCS RX reset, active-high
//  ready_o       out  1        link up: TX and RX released and lock held
//  timeout_o     out  1        one-cycle pulse per lock timeout
//  retry_cnt_o   out  RETRY_W  saturating count of lock timeouts
// BEHAVIOUR
//  Reset: fpga_reset_i=1 gives state=HOLD, cnt=0, retry_cnt=0.
//   Outputs: tx_reset_o=1, rx_reset_o=1, ready_o=0, timeout_o=0, retry_cnt_o=0.
//  Outputs are Moore, decoded from registered state only:
//   tx_reset_o = HOLD
//   rx_reset_o = HOLD | TX_SETTLE | RETRY
//   ready_o    = RUN
//   timeout_o  = first cycle of RETRY (registered flag)
//  cnt: CNT_W bits, cleared on every state change, increments otherwise.
//  States:
//   HOLD:      cnt==HOLD_CYC-1 -> TX_SETTLE
//   TX_SETTLE: cnt==TX_SETTLE_CYC-1 -> WAIT_LOCK
//   WAIT_LOCK: block_lock_i=1 -> RUN;
//              else cnt==LOCK_TIMEOUT-1 -> RETRY, retry_cnt += 1 (saturating at all-ones)
//   RETRY:     cnt==HOLD_CYC-1 -> WAIT_LOCK; TX stays released
//   RUN:       block_lock_i=0 -> WAIT_LOCK; RX not reset, timeout window restarts
//  Timing: cycle 0 = first cycle with fpga_reset_i=0.
//   tx_reset_o falls at cycle HOLD_CYC.
//   rx_reset_o falls at cycle HOLD_CYC+TX_SETTLE_CYC.
//   ready_o rises 1 cycle after lock is sampled in WAIT_LOCK.
//  block_lock_i is ignored in HOLD, TX_SETTLE and RETRY.
//  Lock and timeout in the same cycle: lock wins -> RUN, no timeout_o, retry_cnt unchanged.
//  trig_i=1 in any state: next state HOLD, cnt=0; retry_cnt preserved.
//   A held trig_i keeps the block in HOLD.
//  fpga_reset_i overrides trig_i. Only fpga_reset_i clears retry_cnt.
//  Reset mid-operation in any state: all reset values on the next cycle, no partial outputs.
// STRUCTURE
//  pcs_reset_seq_pkg: state enum (HOLD, TX_SETTLE, WAIT_LOCK, RUN, RETRY) and its encoding width.
//  No sub-module: one counter plus FSM inline, with the saturating retry counter inline.
// TESTING (defaults unless stated)
//  1. Release fpga_reset_i, lock=1 constant -> tx_reset_o low at cyc 16, rx_reset_o low at 24,
//     ready_o high at 25; timeout_o never pulses.
//  2. lock=0 constant -> timeout_o pulses at cyc 1048 (24+1024); rx_reset_o high cyc 1048..1063;
//     WAIT_LOCK again at 1064; retry_cnt_o=1; tx_reset_o stays 0.
//  3. RETRY_W=2, lock=0 for 5 timeout windows -> retry_cnt_o reads 1,2,3,3,3; timeout_o pulses 5 times.
//  4. In RUN, drop lock for 1 cycle -> ready_o low on the next cycle; tx/rx resets stay 0;
//     ready_o high again 1 cycle after lock returns.
//  5. trig_i pulse in RUN with retry_cnt_o=2 -> next cycle tx/rx resets=1, ready_o=0;
//     16/8 release sequence repeats; retry_cnt_o stays 2.
//  6. Lock rises on cnt==1023 in WAIT_LOCK -> RUN, no timeout_o.
//     fpga_reset_i asserted in WAIT_LOCK -> next cycle outputs 1,1,0,0,0.

Source files
------------

// File: rtl/pcs_reset_seq_pkg.sv
// pcs_reset_seq_pkg: state encoding and sizing helpers for the PCS reset sequencer
package pcs_reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        HOLD,
        TX_SETTLE,
        WAIT_LOCK,
        RUN,
        RETRY
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pcs_reset_seq.sv
// pcs_reset_seq: staged TX/RX PCS reset release with block-lock wait, timeout and retry
module pcs_reset_seq
    import pcs_reset_seq_pkg::*;
#(
    parameter int HOLD_CYC      = 16,
    parameter int TX_SETTLE_CYC = 8,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int RETRY_W       = 8
) (
    input  logic               clk,
    input  logic               fpga_reset_i,
    input  logic               trig_i,
    input  logic               block_lock_i,
    output logic               tx_reset_o,
    output logic               rx_reset_o,
    output logic               ready_o,
    output logic               timeout_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam int CNT_W = $clog2(max3(HOLD_CYC, TX_SETTLE_CYC, LOCK_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(TX_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);

    if (HOLD_CYC < 1 || TX_SETTLE_CYC < 1 || LOCK_TIMEOUT < 1 || RETRY_W < 1) begin : g_param_check
        $error("pcs_reset_seq: cycle parameters and RETRY_W must be >= 1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               timeout_q;

    // sequencer: reset beats trigger, trigger beats normal progress; cnt restarts on every state change
    always_ff @(posedge clk) begin
        if (fpga_reset_i) begin
            state     <= HOLD;
            cnt       <= '0;
            retry_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (trig_i) begin
            state     <= HOLD;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= TX_SETTLE;
                        cnt   <= '0;
                    end
                end
                TX_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                WAIT_LOCK: begin
                    if (block_lock_i) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == TMO_LAST) begin
                        state     <= RETRY;
                        cnt       <= '0;
                        timeout_q <= 1'b1;
                        retry_cnt <= (&retry_cnt) ? retry_cnt : retry_cnt + RETRY_W'(1);
                    end
                end
                RETRY: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!block_lock_i) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign tx_reset_o  = (state == HOLD);
    assign rx_reset_o  = (state == HOLD) || (state == TX_SETTLE) || (state == RETRY);
    assign ready_o     = (state == RUN);
    assign timeout_o   = timeout_q;
    assign retry_cnt_o = retry_cnt;

endmodule

// File: tb/tb_pcs_reset_seq.sv
// tb_pcs_reset_seq: scoreboard bench for the PCS reset sequencer with a 2-bit retry counter
module tb_pcs_reset_seq;

    logic       clk = 1'b0;
    logic       fpga_reset_i = 1'b1;
    logic       trig_i = 1'b0;
    logic       block_lock_i = 1'b1;
    logic       tx_reset_o, rx_reset_o, ready_o, timeout_o;
    logic [1:0] retry_cnt_o;

    pcs_reset_seq #(.RETRY_W(2)) dut (
        .clk          (clk),
        .fpga_reset_i (fpga_reset_i),
        .trig_i       (trig_i),
        .block_lock_i (block_lock_i),
        .tx_reset_o   (tx_reset_o),
        .rx_reset_o   (rx_reset_o),
        .ready_o      (ready_o),
        .timeout_o    (timeout_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        string      name;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_to = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string nm, input logic tx, input logic rx,
                             input logic rdy, input logic to, input int rc);
        exp_t e;
        e.c    = c;
        e.name = nm;
        e.v    = {tx, rx, rdy, to, 2'(rc)};
        q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: compares every scheduled expectation in its cycle, then closes the run
    always @(negedge clk) begin
        logic [5:0] got;
        got = {tx_reset_o, rx_reset_o, ready_o, timeout_o, retry_cnt_o};
        if (timeout_o) n_to++;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].c <= cyc) begin
                n_chk++;
                if (q[i].c < cyc || got !== q[i].v) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got tx,rx,rdy,to,rc=%b exp=%b (due cyc %0d)",
                             q[i].name, cyc, got, q[i].v, q[i].c);
                end
                q.delete(i);
            end
        end
        if (done) begin
            n_chk++;
            if (q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_expectations got=%0d exp=0", q.size());
            end
            n_chk++;
            if (n_to != 7) begin
                n_fail++;
                $display("FAIL timeout_pulse_count got=%0d exp=7", n_to);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, t;
        @(posedge clk);
        #1;
        expect_at(cyc + 1, "in_reset", 1, 1, 0, 0, 0);
        goto(cyc + 3);
        // lock held high: staged release then ready
        fpga_reset_i = 1'b0;
        a = cyc;
        expect_at(a,      "a_cyc0",      1, 1, 0, 0, 0);
        expect_at(a + 15, "a_hold_end",  1, 1, 0, 0, 0);
        expect_at(a + 16, "a_tx_rel",    0, 1, 0, 0, 0);
        expect_at(a + 23, "a_settle_end",0, 1, 0, 0, 0);
        expect_at(a + 24, "a_rx_rel",    0, 0, 0, 0, 0);
        expect_at(a + 25, "a_ready",     0, 0, 1, 0, 0);
        expect_at(a + 30, "a_run",       0, 0, 1, 0, 0);
        expect_at(a + 31, "a_lock_drop", 0, 0, 0, 0, 0);
        expect_at(a + 32, "a_relock",    0, 0, 1, 0, 0);
        expect_at(a + 1063, "a_wait_1022", 0, 0, 0, 0, 0);
        expect_at(a + 1064, "a_wait_1023", 0, 0, 0, 0, 0);
        expect_at(a + 1065, "a_lock_wins", 0, 0, 1, 0, 0);
        expect_at(a + 1066, "a_no_tmo",    0, 0, 1, 0, 0);
        goto(a + 30);
        block_lock_i = 1'b0;
        goto(a + 31);
        block_lock_i = 1'b1;
        goto(a + 40);
        block_lock_i = 1'b0;
        goto(a + 1064);
        block_lock_i = 1'b1;
        goto(a + 1070);
        // reset from RUN, then no lock: timeouts and retries
        fpga_reset_i = 1'b1;
        block_lock_i = 1'b0;
        expect_at(a + 1071, "b_reset_run", 1, 1, 0, 0, 0);
        goto(a + 1071);
        fpga_reset_i = 1'b0;
        b = cyc;
        expect_at(b + 24,   "b_rx_rel",     0, 0, 0, 0, 0);
        expect_at(b + 1047, "b_pre_tmo",    0, 0, 0, 0, 0);
        expect_at(b + 1048, "b_tmo1",       0, 1, 0, 1, 1);
        expect_at(b + 1049, "b_retry",      0, 1, 0, 0, 1);
        expect_at(b + 1063, "b_retry_end",  0, 1, 0, 0, 1);
        expect_at(b + 1064, "b_rewait",     0, 0, 0, 0, 1);
        expect_at(b + 2088, "b_tmo2",       0, 1, 0, 1, 2);
        expect_at(b + 2104, "b_rewait2",    0, 0, 0, 0, 2);
        expect_at(b + 2111, "b_run_rc2",    0, 0, 1, 0, 2);
        expect_at(b + 2116, "b_trig_hold",  1, 1, 0, 0, 2);
        expect_at(b + 2131, "b_trig_hend",  1, 1, 0, 0, 2);
        expect_at(b + 2132, "b_trig_tx",    0, 1, 0, 0, 2);
        expect_at(b + 2140, "b_trig_rx",    0, 0, 0, 0, 2);
        expect_at(b + 2141, "b_trig_ready", 0, 0, 1, 0, 2);
        expect_at(b + 2179, "b_held_trig",  1, 1, 0, 0, 2);
        expect_at(b + 2195, "b_held_hend",  1, 1, 0, 0, 2);
        expect_at(b + 2196, "b_held_tx",    0, 1, 0, 0, 2);
        expect_at(b + 2205, "b_held_ready", 0, 0, 1, 0, 2);
        expect_at(b + 2211, "b_wait",       0, 0, 0, 0, 2);
        expect_at(b + 2221, "b_reset_wait", 1, 1, 0, 0, 0);
        goto(b + 2110);
        block_lock_i = 1'b1;
        goto(b + 2115);
        trig_i = 1'b1;
        goto(b + 2116);
        trig_i = 1'b0;
        goto(b + 2150);
        trig_i = 1'b1;
        goto(b + 2180);
        trig_i = 1'b0;
        goto(b + 2210);
        block_lock_i = 1'b0;
        goto(b + 2220);
        fpga_reset_i = 1'b1;
        trig_i = 1'b1;
        goto(b + 2221);
        fpga_reset_i = 1'b0;
        trig_i = 1'b0;
        // five timeout windows: retry counter saturates at 3
        c = cyc;
        expect_at(c, "c_cyc0", 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            t = c + 1048 + 1040 * k;
            expect_at(t - 1, $sformatf("c_pre_tmo%0d", k), 0, 0, 0, 0, (k > 3) ? 3 : k);
            expect_at(t,     $sformatf("c_tmo%0d", k),     0, 1, 0, 1, (k + 1 > 3) ? 3 : k + 1);
            expect_at(t + 1, $sformatf("c_retry%0d", k),   0, 1, 0, 0, (k + 1 > 3) ? 3 : k + 1);
        end
        goto(c + 1048 + 4 * 1040 + 20);
        done = 1'b1;
    end

endmodule
